regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single register-file write port (rw/wn/wd) between the in-order pipeline writeback stage and the multi-cycle execution unit (mult/div, slow loads). The pipeline has fixed priority. The multi-cycle unit uses a valid/ready handshake, and a starvation counter forces a one-cycle pipeline stall so the unit's result is eventually committed. The block sits between writeback and register_file, drives its write inputs from registered outputs, and stalls the pipeline when required.

## Interface
- SIZE, 32, number of architectural registers
- WIDTH, 32, register data width
- MAX_WAIT, 4, consecutive refused cycles tolerated by the multi-cycle unit before a forced grant (≥1)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- p_wn  input  1  pipeline writeback request
- p_rw  input  $clog2(SIZE)  pipeline destination register
- p_wd  input  WIDTH  pipeline write data
- m_valid  input  1  multi-cycle unit result valid
- m_rw  input  $clog2(SIZE)  multi-cycle destination register
- m_wd  input  WIDTH  multi-cycle write data
- m_ready  output  1  combinational; the result is accepted in a cycle where m_valid && m_ready
- stall  output  1  registered; pipeline holds all stages, including p_wn/p_rw/p_wd
- wn  output  1  registered write enable to register_file
- rw  output  $clog2(SIZE)  registered write index
- wd  output  WIDTH  registered write data

## Operation
- States: NORMAL and STARVE. The state register and wait_cnt (width $clog2(MAX_WAIT)+1) are cleared by reset.
- NORMAL, p_wn=1 with p_rw≠0: grant pipeline. If m_valid, drive m_ready=0 and increment wait_cnt.
- NORMAL, p_wn=0 or p_rw=0: drive m_ready=m_valid. On the handshake, grant the multi-cycle unit and clear wait_cnt.
- NORMAL → STARVE: at the edge where the pipeline is granted, m_valid=1 and wait_cnt==MAX_WAIT-1.
- STARVE: stall=1. m_ready=m_valid; the multi-cycle unit is granted and p_wn is ignored (the pipeline re-presents the same request next cycle).
- STARVE → NORMAL: after the handshake, with wait_cnt cleared. If m_valid is low in STARVE (withdrawn), return to NORMAL without a grant.
- Requests with destination 0 are accepted but produce wn=0. A pipeline rw=0 does not occupy the port; an m_rw=0 handshake completes with no write.
- The granted request is captured into wn/rw/wd. If no grant occurs, wn=0 and rw/wd hold their previous values.
- m_valid must hold m_rw/m_wd stable until the handshake. The unit must not drop m_valid except after the handshake.
- WAW/RAW ordering between the two sources is the issue logic's responsibility. This block only serialises writes.

## Timing
- Reset values: wn=0, rw=0, wd=0, stall=0, m_ready=m_valid (NORMAL, p_wn low during reset), state=NORMAL, wait_cnt=0.
- Latency: a grant in cycle n gives wn/rw/wd valid in cycle n+1, and register_file commits at the edge ending cycle n+1.
- stall is high for exactly the cycle spent in STARVE, which is the cycle after the MAX_WAIT-th refusal.
- Worst-case wait from m_valid rise to handshake: MAX_WAIT+1 cycles.
- Simultaneous requests in NORMAL: the pipeline always wins unless the transition to STARVE is pending.
- Reset mid-STARVE or with wn=1 pending: the pending write is discarded and wn=0 immediately (asynchronous).
- MAX_WAIT=1: the first refusal already forces STARVE on the next cycle.

## Structure
- Shared package: state encoding (NORMAL=0, STARVE=1) and REG_ZERO=0, alongside the existing register-index width constants.
- No sub-module. The counter, FSM and output register are in a single module of about 150 lines.

## Test plan
- Pipeline-only write: p_wn=1, p_rw=5, p_wd=0x1234 in cycle 0 → wn=1, rw=5, wd=0x1234 in cycle 1; stall=0 throughout.
- Idle port: m_valid=1, m_rw=8, m_wd=0xCAFE with p_wn=0 → m_ready=1 the same cycle; wn=1, rw=8, wd=0xCAFE next cycle; wait_cnt=0.
- Starvation, MAX_WAIT=4: p_wn=1 every cycle, m_valid=1 from cycle 0 → m_ready=0 in cycles 0-3, stall=1 and m_ready=1 in cycle 4; cycle 5 shows the m write; stall=0 and pipeline writes resume from cycle 5.
- Zero register: p_rw=0 with p_wn=1 while m_valid=1 → m_ready=1 that cycle and wn reflects only the m write. m_rw=0 handshake → wn=0.
- Async reset in STARVE with wn=1: assert rst mid-cycle → wn=0, stall=0 and state=NORMAL before the next edge; after release, the first request is granted normally.
- Withdrawn request in STARVE: force STARVE, then drop m_valid → no write, returns to NORMAL next cycle, wait_cnt=0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Register-index sizing and arbiter state encoding.
package regfile_write_arbiter_pkg;

    localparam int ARCH_REGS = 32;
    localparam int REG_IDX_W = $clog2(ARCH_REGS);
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between the writeback stage
// and the multi-cycle unit, forcing a stall if the latter starves.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int SIZE     = ARCH_REGS,
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p_wn,
    input  logic [$clog2(SIZE)-1:0] p_rw,
    input  logic [WIDTH-1:0]        p_wd,
    input  logic                    m_valid,
    input  logic [$clog2(SIZE)-1:0] m_rw,
    input  logic [WIDTH-1:0]        m_wd,
    output logic                    m_ready,
    output logic                    stall,
    output logic                    wn,
    output logic [$clog2(SIZE)-1:0] rw,
    output logic [WIDTH-1:0]        wd
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(MAX_WAIT) + 1;

    arb_state_e    state;
    logic [CW-1:0] wait_cnt;

    logic p_req;
    logic m_hs;
    logic refuse;
    logic last_refusal;

    // A pipeline write to r0 does not occupy the port.
    assign p_req = p_wn && (p_rw != AW'(REG_ZERO));

    always_comb begin
        m_ready = m_valid;
        if (state == NORMAL && p_req) begin
            m_ready = 1'b0;
        end
    end

    assign m_hs         = m_valid && m_ready;
    assign refuse       = (state == NORMAL) && p_req && m_valid;
    assign last_refusal = (wait_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            stall    <= 1'b0;
            wn       <= 1'b0;
            rw       <= '0;
            wd       <= '0;
        end else begin
            wn    <= 1'b0;
            stall <= 1'b0;

            if (m_hs) begin
                wn <= (m_rw != AW'(REG_ZERO));
                rw <= m_rw;
                wd <= m_wd;
            end else if (state == NORMAL && p_req) begin
                wn <= 1'b1;
                rw <= p_rw;
                wd <= p_wd;
            end

            if (refuse) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end

            // STARVE always lasts one cycle, with or without a handshake.
            unique case (state)
                NORMAL: begin
                    if (refuse && last_refusal) begin
                        state <= STARVE;
                        stall <= 1'b1;
                    end
                end
                STARVE: begin
                    state <= NORMAL;
                end
                default: begin
                    state <= NORMAL;
                end
            endcase
        end
    end

endmodule
